rx_case_fifo: RTL

- Sits directly downstream of the UART receiver; consumes its one-cycle byte strobe.
- Converts each byte's letter case:
  - all-upper mode: every letter becomes upper case.
  - sentence-case mode: first letter of each sentence upper case, other letters lower case.
- Buffers results in a show-ahead FIFO, offered to the transmitter with a valid/ready handshake.
- The receiver has no backpressure, so the block reports overflow instead of stalling.

---
 rtl/rx_case_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/rx_case_fifo.sv
// Case-converting show-ahead FIFO sitting between the UART receiver and transmitter.
// Bytes are upper-cased or sentence-cased on entry; a full FIFO drops bytes and flags overflow.
module rx_case_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_mode,
    input  logic        i_clr_ovf,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [AW:0] o_count,
    output logic        o_overflow
);

    typedef enum logic {SOS, MID} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    mem [DEPTH];

    logic       is_upper, is_lower, is_term;
    logic [7:0] xform;
    logic       empty, full, pop, push, drop;

    assign is_upper = (i_data >= 8'h41) && (i_data <= 8'h5A);
    assign is_lower = (i_data >= 8'h61) && (i_data <= 8'h7A);
    assign is_term  = (i_data == 8'h2E) || (i_data == 8'h21) || (i_data == 8'h3F) ||
                      (i_data == 8'h0A) || (i_data == 8'h0D);

    // Sentence tracking runs on every strobe, even for bytes that get dropped.
    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            if (is_upper || is_lower) state_d = MID;
            else if (is_term)         state_d = SOS;
        end
    end

    always_comb begin
        xform = i_data;
        if (!i_mode || state_q == SOS) begin
            if (is_lower) xform[5] = 1'b0;
        end else begin
            if (is_upper) xform[5] = 1'b1;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign pop   = !empty && i_ready;
    // A pop frees the slot on the same edge, so a full FIFO can still accept.
    assign push  = i_valid && (!full || pop);
    assign drop  = i_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = mem[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (drop)           ovf_d = 1'b1;
        else if (i_clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= SOS;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= xform;
    end

    // While empty, keep showing the byte most recently handed downstream.
    assign o_data     = empty ? hold_q : mem[rd_ptr_q];
    assign o_valid    = !empty;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule
